// File: rtl/lb_pkg.sv
// Shared line-buffer package: default pixel width, pixel type and the
// fill/run state encoding used by the line-buffer stage and its consumers.
package lb_pkg;

  localparam int LB_DATA_W = 8;

  typedef logic [7:0] lb_pix_t;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } lb_fill_state_t;

endpackage

// File: rtl/lb_delay_line.sv
// lb_delay_line: WIN-deep, DATA_W-wide shift register that advances only when
// enabled. Async reset and sync clear both zero every stage. The oldest tap
// is the sample that drops out of the window on the next enabled shift.
module lb_delay_line #(
  parameter int DATA_W = 8,
  parameter int WIN    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] oldest
);

  logic [DATA_W-1:0] taps_q [WIN];
  logic [DATA_W-1:0] taps_d [WIN];

  // Next tap contents: zero on clear, shift by one on enable, else hold.
  always_comb begin
    for (int i = 0; i < WIN; i++) taps_d[i] = taps_q[i];
    if (clear) begin
      for (int i = 0; i < WIN; i++) taps_d[i] = '0;
    end else if (en) begin
      taps_d[0] = din;
      for (int i = 1; i < WIN; i++) taps_d[i] = taps_q[i-1];
    end
  end

  // Tap registers with asynchronous zeroing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WIN; i++) taps_q[i] <= '0;
    end else begin
      taps_q <= taps_d;
    end
  end

  assign oldest = taps_q[WIN-1];

endmodule

// File: rtl/lb_window_avg.sv
// lb_window_avg: sliding box sum / average over the last WIN valid samples of
// the line-buffer pixel stream. One registered result per accepted sample
// once the window is full; no backpressure.
// Build option: define LB_WINDOW_AVG_ROUND_EN for round-half-up averaging
// (saturated to the pixel range); otherwise the average is truncated.
module lb_window_avg
  import lb_pkg::*;
#(
  parameter int DATA_W = LB_DATA_W,
  parameter int WIN    = 4,
  parameter int SUM_W  = DATA_W + $clog2(WIN)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              clear,
  output logic [SUM_W-1:0]  out_sum,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              filling
);

  localparam int LOG2  = $clog2(WIN);
  localparam int CNT_W = $clog2(WIN + 1);

  lb_fill_state_t    state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [SUM_W-1:0]  out_sum_q, out_sum_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              filling_q, filling_d;

  logic              accept;
  logic [DATA_W-1:0] oldest;
  logic [SUM_W-1:0]  sum_n;
  logic [DATA_W-1:0] avg;

  assign accept = in_valid & ~clear;

  lb_delay_line #(
    .DATA_W (DATA_W),
    .WIN    (WIN)
  ) u_delay (
    .clk    (CLK),
    .rst    (RESET),
    .clear  (clear),
    .en     (accept),
    .din    (in_data),
    .oldest (oldest)
  );

  // Running sum after this sample enters and the oldest leaves (wraps freely;
  // the true window sum always fits in SUM_W bits).
  assign sum_n = sum_q + SUM_W'(in_data) - SUM_W'(oldest);

`ifdef LB_WINDOW_AVG_ROUND_EN
  // (s + WIN/2) >> LOG2 equals (s >> LOG2) plus the bit just below the cut,
  // computed one bit wider so the carry is kept, then saturated.
  logic [DATA_W:0] avg_rnd;
  always_comb begin
    avg_rnd = {1'b0, sum_n[SUM_W-1:LOG2]} + (DATA_W+1)'(sum_n[LOG2-1]);
    avg     = avg_rnd[DATA_W] ? {DATA_W{1'b1}} : avg_rnd[DATA_W-1:0];
  end
`else
  // Truncating average: drop the fractional bits.
  assign avg = sum_n[SUM_W-1:LOG2];
`endif

  // Next-state, counter, running sum and result capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    out_sum_d   = out_sum_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    if (clear) begin
      state_d = FILL;
      cnt_d   = '0;
      sum_d   = '0;
    end else if (in_valid) begin
      sum_d = sum_n;
      case (state_q)
        FILL: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIN - 1)) begin
            state_d     = RUN;
            out_valid_d = 1'b1;
          end
        end
        RUN: begin
          out_valid_d = 1'b1;
        end
        default: state_d = FILL;
      endcase
    end
    if (out_valid_d) begin
      out_sum_d  = sum_n;
      out_data_d = avg;
    end
    filling_d = (state_d == FILL);
  end

  // State and output registers, asynchronously returned to the empty window.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      sum_q       <= '0;
      out_sum_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      filling_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      out_sum_q   <= out_sum_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      filling_q   <= filling_d;
    end
  end

  assign out_sum   = out_sum_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign filling   = filling_q;

endmodule
